// File: rtl/fdd_pkg.sv
// Shared types and constants for the floppy host seek sequencer.
package fdd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SPIN,
        S_DIR,
        S_STEP_LO,
        S_STEP_HI,
        S_SETTLE,
        S_DONE,
        S_ERR
    } fdd_state_e;

    localparam logic OP_SEEK  = 1'b0;
    localparam logic OP_RECAL = 1'b1;

    // Shugart bus lines are active-low
    localparam logic ASSERT_N   = 1'b0;
    localparam logic DEASSERT_N = 1'b1;

endpackage

// File: rtl/fdd_step_timer.sv
// Loadable down-counter. tc is high on the last cycle of a loaded wait, so a
// state entered with load_val = N lasts exactly N cycles when it exits on tc.
module fdd_step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load overrides the countdown; counter parks at zero when expired
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == W'(1));

endmodule

// File: rtl/fdd_host_seek.sv
// Host-side seek/recalibrate sequencer for a Shugart floppy bus.
// Optional index period measurement enabled by FDD_INDEX_PERIOD_EN.
module fdd_host_seek
    import fdd_pkg::*;
#(
    parameter int DRIVE_NUM      = 1,
    parameter int MAX_TRACKS     = 80,
    parameter int STEP_PULSE_CYC = 8,
    parameter int STEP_RATE_CYC  = 3000,
    parameter int DIR_SETUP_CYC  = 4,
    parameter int SETTLE_CYC     = 15000,
    parameter int SPINUP_CYC     = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [6:0]  cmd_track,
    input  logic        motor_req,
    output logic        done,
    output logic        err,
    output logic [6:0]  cur_track,
    output logic        trk_valid,
    output logic [3:0]  drive_sel_n,
    output logic        motor_on_n,
    output logic        dir_sel_n,
    output logic        step_n,
    input  logic        track_0_n,
    input  logic        index_n
`ifdef FDD_INDEX_PERIOD_EN
   ,output logic [23:0] idx_period,
    output logic        idx_valid
`endif
);

    localparam logic [7:0]  MAX_T     = 8'(MAX_TRACKS);
    localparam logic [7:0]  MAX_STEPS = 8'(MAX_TRACKS + 4);
    localparam logic [15:0] T_SETUP   = 16'(DIR_SETUP_CYC);
    localparam logic [15:0] T_PULSE   = 16'(STEP_PULSE_CYC);
    localparam logic [15:0] T_HIGH    = 16'(STEP_RATE_CYC - STEP_PULSE_CYC);
    localparam logic [15:0] T_SETTLE  = 16'(SETTLE_CYC);
    localparam logic [15:0] SPIN_MAX  = 16'(SPINUP_CYC);
    localparam logic [3:0]  SEL_ON    = ~(4'(1) << DRIVE_NUM);

    fdd_state_e  state, next_state;
    logic        op_q;
    logic [6:0]  tgt_q;
    logic [1:0]  t0_sync;
    logic        track0, motor_on, spun, accept;
    logic [15:0] spin_cnt;
    logic [7:0]  step_cnt;
    logic        tmr_load, tmr_tc;
    logic [15:0] tmr_val;

    assign track0   = (t0_sync[1] == ASSERT_N);
    assign motor_on = (motor_on_n == ASSERT_N);
    assign spun     = (spin_cnt == SPIN_MAX);
    assign accept   = cmd_valid & cmd_ready;

    fdd_step_timer #(.W(16)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Track 00 synchroniser; idles deasserted
    always_ff @(posedge clk) begin
        if (rst) t0_sync <= 2'b11;
        else     t0_sync <= {t0_sync[0], track_0_n};
    end

    // Motor drive and spin-up counter (saturating, cleared while off)
    always_ff @(posedge clk) begin
        if (rst) begin
            motor_on_n <= DEASSERT_N;
            spin_cnt   <= '0;
        end else begin
            motor_on_n <= ~motor_req;
            if (!motor_on)
                spin_cnt <= '0;
            else if (!spun)
                spin_cnt <= spin_cnt + 16'd1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; each timed state loads the timer on entry
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            S_IDLE: if (accept) next_state = S_CHECK;
            S_CHECK: begin
                if (!motor_on)                                  next_state = S_ERR;
                else if (op_q == OP_SEEK && !trk_valid)         next_state = S_ERR;
                else if (op_q == OP_SEEK && {1'b0, tgt_q} >= MAX_T) next_state = S_ERR;
                else if (op_q == OP_SEEK && tgt_q == cur_track) next_state = S_DONE;
                else                                            next_state = S_SPIN;
            end
            S_SPIN: begin
                // motor loss here would otherwise wait forever
                if (!motor_on) next_state = S_ERR;
                else if (spun) begin
                    next_state = S_DIR;
                    tmr_load   = 1'b1;
                    tmr_val    = T_SETUP;
                end
            end
            S_DIR: if (tmr_tc) begin
                tmr_load = 1'b1;
                if (op_q == OP_RECAL && track0) begin
                    next_state = S_SETTLE;
                    tmr_val    = T_SETTLE;
                end else begin
                    next_state = S_STEP_LO;
                    tmr_val    = T_PULSE;
                end
            end
            S_STEP_LO: if (tmr_tc) begin
                next_state = S_STEP_HI;
                tmr_load   = 1'b1;
                tmr_val    = T_HIGH;
            end
            S_STEP_HI: if (tmr_tc) begin
                if (!motor_on)
                    next_state = S_ERR;
                else if (op_q == OP_SEEK ? (cur_track == tgt_q) : track0) begin
                    next_state = S_SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = T_SETTLE;
                end else if (op_q == OP_RECAL && step_cnt >= MAX_STEPS)
                    next_state = S_ERR;
                else begin
                    next_state = S_STEP_LO;
                    tmr_load   = 1'b1;
                    tmr_val    = T_PULSE;
                end
            end
            S_SETTLE: begin
                if (!motor_on)   next_state = S_ERR;
                else if (tmr_tc) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Command capture, direction, head position and recal bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_SEEK;
            tgt_q     <= '0;
            step_cnt  <= '0;
            cur_track <= '0;
            trk_valid <= 1'b0;
            dir_sel_n <= DEASSERT_N;
        end else begin
            if (accept) begin
                op_q     <= cmd_op;
                tgt_q    <= cmd_track;
                step_cnt <= '0;
            end
            if (state == S_SPIN && next_state == S_DIR)
                dir_sel_n <= (op_q == OP_RECAL) ? 1'b1 : (tgt_q < cur_track);
            if (state == S_STEP_LO && tmr_tc) begin
                step_cnt <= step_cnt + 8'd1;
                if (dir_sel_n == 1'b0) begin
                    if (cur_track != 7'h7F) cur_track <= cur_track + 7'd1;
                end else begin
                    if (cur_track != 7'd0)  cur_track <= cur_track - 7'd1;
                end
            end
            if (state == S_SETTLE && next_state == S_DONE && op_q == OP_RECAL) begin
                cur_track <= '0;
                trk_valid <= 1'b1;
            end
            if (next_state == S_ERR && op_q == OP_RECAL)
                trk_valid <= 1'b0;
        end
    end

    // Bus and handshake outputs registered from next state (glitch-free)
    always_ff @(posedge clk) begin
        if (rst) begin
            step_n      <= DEASSERT_N;
            done        <= 1'b0;
            err         <= 1'b0;
            cmd_ready   <= 1'b0;
            drive_sel_n <= 4'hF;
        end else begin
            step_n      <= (next_state == S_STEP_LO) ? ASSERT_N : DEASSERT_N;
            done        <= (next_state == S_DONE) || (next_state == S_ERR);
            err         <= (next_state == S_ERR);
            cmd_ready   <= (next_state == S_IDLE);
            drive_sel_n <= (next_state == S_IDLE) ? 4'hF : SEL_ON;
        end
    end

`ifdef FDD_INDEX_PERIOD_EN
    logic [2:0]  idx_sync;
    logic        idx_armed, idx_fall;
    logic [23:0] idx_cnt;

    assign idx_fall = idx_sync[2] & ~idx_sync[1];

    // Index period: first fall only arms, later falls latch the interval
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_sync   <= 3'b111;
            idx_armed  <= 1'b0;
            idx_cnt    <= '0;
            idx_period <= '0;
            idx_valid  <= 1'b0;
        end else begin
            idx_sync <= {idx_sync[1:0], index_n};
            if (idx_fall) begin
                if (idx_armed) begin
                    idx_period <= idx_cnt;
                    idx_valid  <= 1'b1;
                end
                idx_armed <= 1'b1;
                idx_cnt   <= 24'd1;
            end else if (idx_cnt != 24'hFFFFFF)
                idx_cnt <= idx_cnt + 24'd1;
            else
                idx_valid <= 1'b0;
        end
    end
`else
    logic unused_index;
    assign unused_index = index_n;
`endif

endmodule

// File: tb/tb_fdd_host_seek.sv
// Self-checking bench for fdd_host_seek with a behavioural drive model.
module tb_fdd_host_seek;

    localparam int PULSE = 3, RATE = 20, SETUP = 4, SETTLE = 30, SPINUP = 200;
    localparam int MAXT = 80, DRV = 1;
    localparam logic [3:0] SEL_EXP = 4'b1101;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_op = 1'b0, motor_req = 1'b0, index_n = 1'b1;
    logic [6:0] cmd_track = '0;
    logic cmd_ready, done, err, trk_valid, motor_on_n, dir_sel_n, step_n, track_0_n;
    logic [6:0] cur_track;
    logic [3:0] drive_sel_n;
`ifdef FDD_INDEX_PERIOD_EN
    logic [23:0] idx_period;
    logic        idx_valid;
`endif

    int checks = 0, errors = 0;
    int model_track = 0;
    bit model_valid = 0;

    fdd_host_seek #(
        .DRIVE_NUM(DRV), .MAX_TRACKS(MAXT), .STEP_PULSE_CYC(PULSE), .STEP_RATE_CYC(RATE),
        .DIR_SETUP_CYC(SETUP), .SETTLE_CYC(SETTLE), .SPINUP_CYC(SPINUP)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_track(cmd_track), .motor_req(motor_req), .done(done), .err(err),
        .cur_track(cur_track), .trk_valid(trk_valid), .drive_sel_n(drive_sel_n),
        .motor_on_n(motor_on_n), .dir_sel_n(dir_sel_n), .step_n(step_n),
        .track_0_n(track_0_n), .index_n(index_n)
`ifdef FDD_INDEX_PERIOD_EN
       ,.idx_period(idx_period), .idx_valid(idx_valid)
`endif
    );

    always #5 clk = ~clk;

    // Drive model + step monitor. Control from the stimulus side arrives via toggles.
    int  cyc = 0, nfall = 0, last_fall = 0, dir_chg_cyc = 0, phys_pos = 0, phys_init = 0;
    int  min_sp = 1000000, max_sp = 0, min_lo = 1000000, max_lo = 0, setup_min = 1000000;
    logic prev_step = 1'b1, prev_dir = 1'b1, dir_first = 1'b0, dir_mixed = 1'b0;
    bit  clr_tog = 0, clr_seen = 0, ld_tog = 0, ld_seen = 0, t0_stuck = 0;

    assign track_0_n = (phys_pos == 0 && !t0_stuck) ? 1'b0 : 1'b1;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_step <= step_n;
        prev_dir  <= dir_sel_n;
        if (dir_sel_n != prev_dir) dir_chg_cyc <= cyc;
        if (ld_tog != ld_seen) begin
            ld_seen  <= ld_tog;
            phys_pos <= phys_init;
        end else if (prev_step && !step_n)
            phys_pos <= dir_sel_n ? ((phys_pos > 0) ? phys_pos - 1 : 0) : phys_pos + 1;
        if (clr_tog != clr_seen) begin
            clr_seen <= clr_tog; nfall <= 0; dir_mixed <= 1'b0;
            min_sp <= 1000000; max_sp <= 0; min_lo <= 1000000; max_lo <= 0; setup_min <= 1000000;
        end else begin
            if (prev_step && !step_n) begin
                nfall     <= nfall + 1;
                last_fall <= cyc;
                if (nfall == 0) begin
                    dir_first <= dir_sel_n;
                    setup_min <= cyc - dir_chg_cyc;
                end else begin
                    if (dir_sel_n != dir_first) dir_mixed <= 1'b1;
                    if (cyc - last_fall < min_sp) min_sp <= cyc - last_fall;
                    if (cyc - last_fall > max_sp) max_sp <= cyc - last_fall;
                end
            end
            if (!prev_step && step_n) begin
                if (cyc - last_fall < min_lo) min_lo <= cyc - last_fall;
                if (cyc - last_fall > max_lo) max_lo <= cyc - last_fall;
            end
        end
    end

    // Results of the last command
    bit r_done, r_err, r_rdy;
    int r_lat;
    logic [3:0] r_sel;

    task automatic set_head(input int p);
        phys_init = p;
        ld_tog = ~ld_tog;
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input logic op, input int trk);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        clr_tog = ~clr_tog;
        cmd_valid = 1'b1; cmd_op = op; cmd_track = 7'(trk);
        @(negedge clk);
        cmd_valid = 1'b0;
        r_rdy = cmd_ready; r_sel = drive_sel_n; r_lat = 1;
    endtask

    task automatic run_cmd(input logic op, input int trk);
        issue(op, trk);
        while (!done && r_lat < 20000) begin @(negedge clk); r_lat++; end
        r_done = done; r_err = err;
        checks++; if (!r_done) begin errors++; $display("FAIL cmd_timeout op=%0d trk=%0d lat=%0d", op, trk, r_lat); end
    endtask

    task automatic test_reset;
        motor_req = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (drive_sel_n !== 4'hF) begin errors++; $display("FAIL rst_sel got %h exp f", drive_sel_n); end
        checks++; if (motor_on_n !== 1'b1) begin errors++; $display("FAIL rst_motor got %b exp 1", motor_on_n); end
        checks++; if (dir_sel_n !== 1'b1) begin errors++; $display("FAIL rst_dir got %b exp 1", dir_sel_n); end
        checks++; if (step_n !== 1'b1) begin errors++; $display("FAIL rst_step got %b exp 1", step_n); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", cmd_ready); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done got %b%b exp 00", done, err); end
        checks++; if (cur_track !== 7'd0 || trk_valid !== 1'b0) begin errors++; $display("FAIL rst_track got %0d/%b exp 0/0", cur_track, trk_valid); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", cmd_ready); end
        checks++; if (motor_on_n !== 1'b0) begin errors++; $display("FAIL post_rst_motor got %b exp 0", motor_on_n); end
        model_track = 0; model_valid = 0;
    endtask

    task automatic test_seek_unknown;
        run_cmd(1'b0, 5);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL seek_unknown_err got %b exp 1", r_err); end
        checks++; if (nfall !== 0) begin errors++; $display("FAIL seek_unknown_steps got %0d exp 0", nfall); end
    endtask

    task automatic test_recal;
        t0_stuck = 0;
        set_head(5);
        run_cmd(1'b1, 0);
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL recal_err got %b exp 0", r_err); end
        checks++; if (nfall !== 5) begin errors++; $display("FAIL recal_steps got %0d exp 5", nfall); end
        checks++; if (dir_first !== 1'b1 || dir_mixed !== 1'b0) begin errors++; $display("FAIL recal_dir got %b/%b exp 1/0", dir_first, dir_mixed); end
        checks++; if (cur_track !== 7'd0 || trk_valid !== 1'b1) begin errors++; $display("FAIL recal_track got %0d/%b exp 0/1", cur_track, trk_valid); end
        checks++; if (r_sel !== SEL_EXP) begin errors++; $display("FAIL recal_sel got %h exp %h", r_sel, SEL_EXP); end
        model_track = 0; model_valid = 1;
    endtask

    task automatic test_seek10;
        run_cmd(1'b0, 10);
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL seek10_err got %b exp 0", r_err); end
        checks++; if (nfall !== 10) begin errors++; $display("FAIL seek10_steps got %0d exp 10", nfall); end
        checks++; if (dir_first !== 1'b0 || dir_mixed !== 1'b0) begin errors++; $display("FAIL seek10_dir got %b/%b exp 0/0", dir_first, dir_mixed); end
        checks++; if (setup_min < SETUP) begin errors++; $display("FAIL seek10_setup got %0d exp >=%0d", setup_min, SETUP); end
        checks++; if (min_sp !== RATE || max_sp !== RATE) begin errors++; $display("FAIL seek10_rate got %0d..%0d exp %0d", min_sp, max_sp, RATE); end
        checks++; if (min_lo !== PULSE || max_lo !== PULSE) begin errors++; $display("FAIL seek10_pulse got %0d..%0d exp %0d", min_lo, max_lo, PULSE); end
        checks++; if (int'(cur_track) !== 10) begin errors++; $display("FAIL seek10_track got %0d exp 10", cur_track); end
        model_track = 10;
    endtask

    task automatic test_noop;
        run_cmd(1'b0, 10);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL noop_latency got %0d exp 2", r_lat); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL noop_err got %b exp 0", r_err); end
        checks++; if (nfall !== 0) begin errors++; $display("FAIL noop_steps got %0d exp 0", nfall); end
        checks++; if (r_rdy !== 1'b0) begin errors++; $display("FAIL noop_ready_drop got %b exp 0", r_rdy); end
        checks++; if (r_sel !== SEL_EXP) begin errors++; $display("FAIL noop_sel got %h exp %h", r_sel, SEL_EXP); end
        @(negedge clk);
        checks++; if (drive_sel_n !== 4'hF) begin errors++; $display("FAIL noop_sel_release got %h exp f", drive_sel_n); end
    endtask

    task automatic test_bad_target;
        run_cmd(1'b0, MAXT);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL bad_target_err got %b exp 1", r_err); end
        checks++; if (nfall !== 0) begin errors++; $display("FAIL bad_target_steps got %0d exp 0", nfall); end
        checks++; if (int'(cur_track) !== model_track) begin errors++; $display("FAIL bad_target_track got %0d exp %0d", cur_track, model_track); end
    endtask

    task automatic test_random_seeks;
        for (int i = 0; i < 10; i++) begin
            int t, exp_steps, exp_track;
            bit exp_err;
            t = int'($urandom_range(0, 89));
            exp_err   = (t >= MAXT);
            exp_steps = exp_err ? 0 : ((t > model_track) ? t - model_track : model_track - t);
            exp_track = exp_err ? model_track : t;
            run_cmd(1'b0, t);
            checks++; if (r_err !== exp_err) begin errors++; $display("FAIL rnd_err t=%0d got %b exp %b", t, r_err, exp_err); end
            checks++; if (nfall !== exp_steps) begin errors++; $display("FAIL rnd_steps t=%0d got %0d exp %0d", t, nfall, exp_steps); end
            checks++; if (int'(cur_track) !== exp_track) begin errors++; $display("FAIL rnd_track t=%0d got %0d exp %0d", t, cur_track, exp_track); end
            if (exp_steps > 0) begin
                checks++; if (dir_first !== logic'(t < model_track) || dir_mixed) begin errors++; $display("FAIL rnd_dir t=%0d got %b exp %b", t, dir_first, t < model_track); end
            end
            if (exp_steps > 1) begin
                checks++; if (min_sp !== RATE || max_sp !== RATE) begin errors++; $display("FAIL rnd_rate t=%0d got %0d..%0d exp %0d", t, min_sp, max_sp, RATE); end
            end
            model_track = exp_track;
        end
    endtask

    task automatic test_motor_off;
        int t;
        t = (model_track < 40) ? model_track + 3 : model_track - 3;
        motor_req = 1'b0;
        repeat (4) @(negedge clk);
        run_cmd(1'b0, t);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL motor_off_err got %b exp 1", r_err); end
        checks++; if (nfall !== 0) begin errors++; $display("FAIL motor_off_steps got %0d exp 0", nfall); end
        checks++; if (int'(cur_track) !== model_track) begin errors++; $display("FAIL motor_off_track got %0d exp %0d", cur_track, model_track); end
        motor_req = 1'b1;
    endtask

    task automatic test_abort;
        bit saw_done = 0;
        issue(1'b0, (model_track < 40) ? 79 : 0);
        repeat (SPINUP + 60) @(negedge clk);
        checks++; if (nfall < 1) begin errors++; $display("FAIL abort_started got %0d steps exp >=1", nfall); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL abort_done got 1 exp 0"); end
        checks++; if (trk_valid !== 1'b0 || cur_track !== 7'd0) begin errors++; $display("FAIL abort_track got %0d/%b exp 0/0", cur_track, trk_valid); end
        checks++; if (step_n !== 1'b1 || drive_sel_n !== 4'hF) begin errors++; $display("FAIL abort_bus got %b/%h exp 1/f", step_n, drive_sel_n); end
        model_track = 0; model_valid = 0;
    endtask

    task automatic test_recal_stuck;
        t0_stuck = 1;
        run_cmd(1'b1, 0);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL stuck_err got %b exp 1", r_err); end
        checks++; if (nfall !== MAXT + 4) begin errors++; $display("FAIL stuck_steps got %0d exp %0d", nfall, MAXT + 4); end
        checks++; if (trk_valid !== 1'b0) begin errors++; $display("FAIL stuck_valid got %b exp 0", trk_valid); end
        checks++; if (dir_first !== 1'b1 || dir_mixed !== 1'b0) begin errors++; $display("FAIL stuck_dir got %b/%b exp 1/0", dir_first, dir_mixed); end
        t0_stuck = 0;
    endtask

`ifdef FDD_INDEX_PERIOD_EN
    task automatic test_index;
        checks++; if (idx_valid !== 1'b0) begin errors++; $display("FAIL idx_initial got %b exp 0", idx_valid); end
        for (int i = 0; i < 3; i++) begin
            index_n = 1'b0;
            repeat (5) @(negedge clk);
            index_n = 1'b1;
            repeat (1995) @(negedge clk);
        end
        checks++; if (idx_valid !== 1'b1) begin errors++; $display("FAIL idx_valid got %b exp 1", idx_valid); end
        checks++; if (idx_period !== 24'd2000) begin errors++; $display("FAIL idx_period got %0d exp 2000", idx_period); end
    endtask
`endif

    initial begin
        test_reset;
        test_seek_unknown;
        test_recal;
        test_seek10;
        test_noop;
        test_bad_target;
        test_random_seeks;
        test_motor_off;
        test_abort;
        test_recal_stuck;
`ifdef FDD_INDEX_PERIOD_EN
        test_index;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
